// File: rtl/out_port_pkg.sv
// Shared opcode encoding and helpers for the output port bank.
package out_port_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE     = 2'b00,
    OP_TOGGLE    = 2'b01,
    OP_PULSE     = 2'b10,
    OP_WRITE_ALL = 2'b11
  } op_e;

  // A zero-length pulse still drives the pin for one cycle.
  function automatic int unsigned clamp_len(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/out_pulse_chan.sv
// One output pin: pin flop, pulse busy flag and pulse down-counter.
module out_pulse_chan
  import out_port_pkg::*;
#(
  parameter int unsigned PULSE_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  op_e                op_i,
  input  logic               bit_i,
  input  logic               all_bit_i,
  input  logic [PULSE_W-1:0] len_i,
  output logic               dout_o,
  output logic               busy_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e             state_q;
  logic               dout_q;
  logic [PULSE_W-1:0] cnt_q;

  // Reset is synchronous; an in-flight pulse is dropped and the pin forced low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            unique case (op_i)
              OP_WRITE:     dout_q <= bit_i;
              OP_TOGGLE:    dout_q <= ~dout_q;
              OP_WRITE_ALL: dout_q <= all_bit_i;
              OP_PULSE: begin
                dout_q  <= 1'b1;
                cnt_q   <= len_i;
                state_q <= StActive;
              end
              default: ;
            endcase
          end
        end
        StActive: begin
          if (cnt_q == PULSE_W'(1)) begin
            dout_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - PULSE_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q == StActive);

endmodule

// File: rtl/out_port_bank.sv
// Registered GPIO output bank with write/toggle/pulse/write-all commands.
// Define OUT_PORT_BANK_OE_EN to add the oe output-enable register (op 11, pin 1).
module out_port_bank
  import out_port_pkg::*;
#(
  parameter int unsigned NUM_PINS = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_PINS),
  parameter int unsigned PULSE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [SEL_W-1:0]    cmd_pin,
  input  logic                cmd_bit,
  input  logic [NUM_PINS-1:0] cmd_all,
  input  logic [PULSE_W-1:0]  pulse_len,
  output logic [NUM_PINS-1:0] dout,
  output logic [NUM_PINS-1:0] busy,
`ifdef OUT_PORT_BANK_OE_EN
  output logic [NUM_PINS-1:0] oe,
`endif
  output logic                cmd_err
);

  op_e                 op;
  logic [NUM_PINS-1:0] pin_sel;
  logic [NUM_PINS-1:0] chan_load;
  logic [PULSE_W-1:0]  len_clamped;
  logic                pin_ok, pin_busy, is_wall, is_oe, bad_pin, accept;
  logic                err_q;

  assign op          = op_e'(cmd_op);
  assign pin_ok      = 32'(cmd_pin) < NUM_PINS;
  assign pin_busy    = |(busy & pin_sel);
  assign len_clamped = PULSE_W'(clamp_len(32'(pulse_len)));
  assign accept      = cmd_valid & cmd_ready;

  always_comb begin
    pin_sel = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      pin_sel[i] = (32'(cmd_pin) == i);
    end
  end

  // Out-of-range pins are always ready so the command drains and flags an error.
  always_comb begin
    is_wall   = 1'b0;
    is_oe     = 1'b0;
    bad_pin   = 1'b0;
    cmd_ready = 1'b1;
    if (op == OP_WRITE_ALL) begin
`ifdef OUT_PORT_BANK_OE_EN
      if (cmd_pin == '0) begin
        is_wall = 1'b1;
      end else if (32'(cmd_pin) == 1) begin
        is_oe = 1'b1;
      end else begin
        bad_pin = 1'b1;
      end
`else
      is_wall = 1'b1;
`endif
      cmd_ready = is_wall ? (busy == '0) : 1'b1;
    end else begin
      bad_pin   = !pin_ok;
      cmd_ready = bad_pin | !pin_busy;
    end
  end

  always_comb begin
    chan_load = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      chan_load[i] = accept & (is_wall | ((op != OP_WRITE_ALL) & pin_sel[i]));
    end
  end

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_chan
    out_pulse_chan #(
      .PULSE_W(PULSE_W)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .load_i   (chan_load[g]),
      .op_i     (op),
      .bit_i    (cmd_bit),
      .all_bit_i(cmd_all[g]),
      .len_i    (len_clamped),
      .dout_o   (dout[g]),
      .busy_o   (busy[g])
    );
  end

`ifdef OUT_PORT_BANK_OE_EN
  logic [NUM_PINS-1:0] oe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe_q <= '0;
    end else if (accept & is_oe) begin
      oe_q <= cmd_all;
    end
  end

  assign oe = oe_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & bad_pin;
    end
  end

  assign cmd_err = err_q;

endmodule

// File: tb/tb_out_port_bank.sv
// Scoreboard bench for out_port_bank (6 pins so out-of-range selects are reachable).
module tb_out_port_bank;

  localparam int unsigned NP = 6;
  localparam int unsigned SW = 3;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [SW-1:0] cmd_pin;
  logic          cmd_bit;
  logic [NP-1:0] cmd_all;
  logic [PW-1:0] pulse_len;
  logic [NP-1:0] dout;
  logic [NP-1:0] busy;
  logic          cmd_err;
`ifdef OUT_PORT_BANK_OE_EN
  logic [NP-1:0] oe;
`endif

  out_port_bank #(
    .NUM_PINS(NP),
    .PULSE_W (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_pin  (cmd_pin),
    .cmd_bit  (cmd_bit),
    .cmd_all  (cmd_all),
    .pulse_len(pulse_len),
    .dout     (dout),
    .busy     (busy),
`ifdef OUT_PORT_BANK_OE_EN
    .oe       (oe),
`endif
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Expected view at this cycle: ready for the applied inputs, outputs from the last edge.
  typedef struct {
    int            step;
    logic          rdy;
    logic [NP-1:0] d;
    logic [NP-1:0] bz;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, req);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, once inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("cmd_ready", x.step, 32'(cmd_ready), 32'(x.rdy));
        chk("dout", x.step, 32'(dout), 32'(x.d));
        chk("busy", x.step, 32'(busy), 32'(x.bz));
        chk("cmd_err", x.step, 32'(cmd_err), 32'(x.e));
      end
    end
  end

  task automatic step(input logic rst, input logic v, input logic [1:0] op,
                      input logic [SW-1:0] pin, input logic b, input logic [NP-1:0] all,
                      input logic [PW-1:0] len, input logic rdy, input logic [NP-1:0] d,
                      input logic [NP-1:0] bz, input logic e);
    exp_t x;
    @(negedge clk);
    rst_n     = rst;
    cmd_valid = v;
    cmd_op    = op;
    cmd_pin   = pin;
    cmd_bit   = b;
    cmd_all   = all;
    pulse_len = len;
    x.step = step_no;
    x.rdy  = rdy;
    x.d    = d;
    x.bz   = bz;
    x.e    = e;
    q.push_back(x);
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_pin = '0;
    cmd_bit = 1'b0; cmd_all = '0; pulse_len = '0;
    repeat (2) @(negedge clk);
    //    rst v  op     pin   b     all        len   rdy   dout       busy       err
    step(0, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0); // reset
    step(1, 1, 2'd0, 3'd2, 1, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0); // write p2
    step(1, 1, 2'd1, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000100, 6'b000000, 0); // toggle p0
    step(1, 1, 2'd1, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000101, 6'b000000, 0); // toggle p0
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000100, 6'b000000, 0);
    step(1, 1, 2'd2, 3'd1, 0, 6'b000000, 8'd3, 1, 6'b000100, 6'b000000, 0); // pulse p1 x3
    step(1, 1, 2'd0, 3'd1, 0, 6'b000000, 8'd0, 0, 6'b000110, 6'b000010, 0); // p1 held off
    step(1, 1, 2'd0, 3'd3, 1, 6'b000000, 8'd0, 1, 6'b000110, 6'b000010, 0); // p3 passes
    step(1, 1, 2'd0, 3'd1, 0, 6'b000000, 8'd0, 0, 6'b001110, 6'b000010, 0);
    step(1, 1, 2'd0, 3'd1, 0, 6'b000000, 8'd0, 1, 6'b001100, 6'b000000, 0); // pulse done
    step(1, 1, 2'd2, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001100, 6'b000000, 0); // pulse len 0
    step(1, 1, 2'd3, 3'd0, 0, 6'b001010, 8'd0, 0, 6'b001101, 6'b000001, 0); // wall held
    step(1, 1, 2'd3, 3'd0, 0, 6'b001010, 8'd0, 1, 6'b001100, 6'b000000, 0);
    step(1, 1, 2'd0, 3'd7, 1, 6'b000000, 8'd0, 1, 6'b001010, 6'b000000, 0); // bad pin 7
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001010, 6'b000000, 1);
    step(1, 1, 2'd2, 3'd2, 0, 6'b000000, 8'd10, 1, 6'b001010, 6'b000000, 0); // pulse p2 x10
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001110, 6'b000100, 0);
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001110, 6'b000100, 0);
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001110, 6'b000100, 0);
    step(0, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b001110, 6'b000100, 0); // reset mid-pulse
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0);
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0);
    step(1, 1, 2'd1, 3'd6, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0); // bad pin 6
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 1);
    step(1, 0, 2'd0, 3'd0, 0, 6'b000000, 8'd0, 1, 6'b000000, 6'b000000, 0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", step_no, 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
